msb_serializer: RTL and testbench

- Upstream feeder for the multiple-of-three detector FSM.
- Accepts a parallel binary word through a valid/ready handshake and emits it one bit per cycle, MSB first. The detector's `in` port consumes that bit stream.
- Emits frame markers so downstream logic can restart its remainder at each new number and sample the verdict on the last bit.
- Supports variable word length and downstream stall.

---
 rtl/msb_serializer_pkg.sv | 15 +
 rtl/msb_serializer.sv | 81 ++++++++
 tb/tb_msb_serializer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/msb_serializer_pkg.sv
// Shared types and helpers for the MSB-first word serializer.
// Holds the FSM state encoding and the effective-length rule.
package msb_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A length of 0, or one larger than the word, means "send the whole word".
    function automatic logic [31:0] eff_len(input logic [31:0] len, input logic [31:0] width);
        return (len == 32'd0 || len > width) ? width : len;
    endfunction

endpackage

// File: rtl/msb_serializer.sv
// Parallel-to-serial converter feeding the multiple-of-three detector.
// Sends the low L bits of each word MSB first, with frame markers and stall support.
module msb_serializer
    import msb_serializer_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic [LW-1:0]    len_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [LW-1:0]    count;
    logic [LW-1:0]    load_len;
    logic             load_bit;
    logic             shift_bit;
    logic             load;
    logic             consume;

    // Bit selects are done with a one-hot mask so the index width need not match WIDTH.
    always_comb begin
        load_len  = LW'(eff_len(32'(len_in), 32'(WIDTH)));
        load_bit  = |(word_in & (WIDTH'(1) << (load_len - 1'b1)));
        shift_bit = |(shreg & (WIDTH'(1) << (count - 2'd2)));
    end

    // Accept on the same edge that consumes the last bit so frames run back to back.
    assign word_ready = (state == IDLE) || (state == SHIFT && last_bit && bit_ready);
    assign load       = word_valid && word_ready;
    assign consume    = (state == SHIFT) && bit_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            count     <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            first_bit <= 1'b0;
            last_bit  <= 1'b0;
            busy      <= 1'b0;
        end else if (load) begin
            state     <= SHIFT;
            shreg     <= word_in;
            count     <= load_len;
            bit_out   <= load_bit;
            bit_valid <= 1'b1;
            first_bit <= 1'b1;
            last_bit  <= (load_len == LW'(1));
            busy      <= 1'b1;
        end else if (consume) begin
            if (count == LW'(1)) begin
                state     <= IDLE;
                count     <= '0;
                bit_out   <= 1'b0;
                bit_valid <= 1'b0;
                first_bit <= 1'b0;
                last_bit  <= 1'b0;
                busy      <= 1'b0;
            end else begin
                count     <= count - 1'b1;
                bit_out   <= shift_bit;
                first_bit <= 1'b0;
                last_bit  <= (count == LW'(2));
            end
        end
    end

endmodule

// File: tb/tb_msb_serializer.sv
// Bench for msb_serializer: a frame-level queue model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_msb_serializer;

    localparam int WIDTH = 10;
    localparam int LW    = $clog2(WIDTH + 1);

    typedef struct {
        bit b;
        bit f;
        bit l;
    } exp_bit_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] word_in = '0;
    logic [LW-1:0]    len_in = '0;
    logic             word_valid = 1'b0;
    logic             word_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_ready = 1'b1;
    logic             first_bit;
    logic             last_bit;
    logic             busy;

    msb_serializer #(.WIDTH(WIDTH), .LW(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .word_in    (word_in),
        .len_in     (len_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .first_bit  (first_bit),
        .last_bit   (last_bit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int       n_checks = 0;
    int       n_errors = 0;
    exp_bit_t q[$];
    bit       hs_seen = 0;
    bit       rand_rdy = 0;
    int       n_consumed = 0;
    logic [31:0] cap_val = 0;
    int       cap_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Model: queue of bits still owed for the current frame, front = bit on the wire.
    always @(negedge reset) q.delete();

    always @(negedge clk) begin
        bit exp_rdy;
        int L;
        if (!reset) begin
            chk("rst_bit_valid", bit_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_bit_out", bit_out, 0);
            chk("rst_first", first_bit, 0);
            chk("rst_last", last_bit, 0);
            q.delete();
            hs_seen = 0;
        end else begin
            exp_rdy = (q.size() == 0) || (q.size() == 1 && bit_ready);
            chk("bit_valid", bit_valid, q.size() != 0);
            chk("busy", busy, q.size() != 0);
            chk("word_ready", word_ready, exp_rdy);
            if (q.size() != 0) begin
                chk("bit_out", bit_out, q[0].b);
                chk("first_bit", first_bit, q[0].f);
                chk("last_bit", last_bit, q[0].l);
                if (bit_ready) begin
                    void'(q.pop_front());
                    cap_val = (cap_val << 1) | 32'(bit_out);
                    cap_n++;
                    n_consumed++;
                end
            end
            hs_seen = word_valid && exp_rdy;
            if (hs_seen) begin
                L = (len_in == 0 || int'(len_in) > WIDTH) ? WIDTH : int'(len_in);
                for (int i = L - 1; i >= 0; i--)
                    q.push_back('{b: word_in[i], f: (i == L - 1), l: (i == 0)});
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bit_ready = ($urandom_range(3) != 0);
        end
    end

    // Leaves word_valid high so a following call can form a back-to-back frame.
    task automatic send(input logic [WIDTH-1:0] w, input logic [LW-1:0] l, input bit scramble);
        int t = 0;
        word_in    = w;
        len_in     = l;
        word_valid = 1'b1;
        do begin
            @(posedge clk);
            #1;
            t++;
            if (!hs_seen && scramble) begin
                word_in = WIDTH'($urandom);
                len_in  = LW'($urandom);
            end
        end while (!hs_seen && t < 300);
        if (!hs_seen) fail_timeout("send_handshake");
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || bit_valid) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) fail_timeout("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cap();
        cap_val = 0;
        cap_n   = 0;
    endtask

    task automatic wait_consumed(input int n);
        int base = n_consumed;
        int t = 0;
        while (n_consumed - base < n && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) fail_timeout("wait_consumed");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", word_ready, 1);

        // Basic frame: 597 over all 10 bits; 597 is a multiple of three.
        clr_cap();
        send(10'd597, 4'd10, 0);
        word_valid = 1'b0;
        drain();
        chk("basic_count", cap_n, 10);
        chk("basic_stream", cap_val, 32'b1001010101);
        chk("basic_mod3", (cap_val % 3) == 0, 1);

        // Short lengths ignore upper bits.
        clr_cap();
        send(10'h3FF, 4'd3, 0);
        word_valid = 1'b0;
        drain();
        chk("short3_count", cap_n, 3);
        chk("short3_val", cap_val, 7);
        chk("short3_mod3", (cap_val % 3) == 0, 0);
        clr_cap();
        send(10'h3FF, 4'd2, 0);
        word_valid = 1'b0;
        drain();
        chk("short2_val", cap_val, 3);
        chk("short2_mod3", (cap_val % 3) == 0, 1);

        // Back-to-back: 6/len3 then 9/len4 with valid held high.
        clr_cap();
        send(10'd6, 4'd3, 0);
        send(10'd9, 4'd4, 0);
        word_valid = 1'b0;
        drain();
        chk("b2b_count", cap_n, 7);
        chk("b2b_stream", cap_val, 32'b1101001);

        // Stall for three cycles mid-frame.
        clr_cap();
        send(10'd597, 4'd10, 0);
        word_valid = 1'b0;
        wait_consumed(3);
        bit_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bit_ready = 1'b1;
        drain();
        chk("stall_count", cap_n, 10);
        chk("stall_stream", cap_val, 32'b1001010101);

        // Asynchronous reset mid-frame.
        send(10'd597, 4'd10, 0);
        word_valid = 1'b0;
        wait_consumed(4);
        #2 reset = 1'b0;
        #1;
        chk("async_bit_valid", bit_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_bit_out", bit_out, 0);
        chk("async_first", first_bit, 0);
        chk("async_last", last_bit, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("ready_after_midreset", word_ready, 1);
        @(posedge clk);
        #1;
        clr_cap();
        send(10'd3, 4'd2, 0);
        word_valid = 1'b0;
        drain();
        chk("post_reset_count", cap_n, 2);
        chk("post_reset_val", cap_val, 3);

        // Length edges: 0 means full width, 1 is a single first+last bit.
        clr_cap();
        send(10'd597, 4'd0, 0);
        word_valid = 1'b0;
        drain();
        chk("len0_count", cap_n, 10);
        chk("len0_val", cap_val, 597);
        clr_cap();
        send(10'd1, 4'd1, 0);
        word_valid = 1'b0;
        #3;
        chk("len1_first", first_bit, 1);
        chk("len1_last", last_bit, 1);
        drain();
        chk("len1_count", cap_n, 1);
        chk("len1_val", cap_val, 1);

        // Randomized traffic with random stalls, gaps and input churn while not ready.
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            int gap = $urandom_range(2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send(WIDTH'($urandom), LW'($urandom), bit'($urandom_range(1)));
            if ($urandom_range(1) == 0) word_valid = 1'b0;
        end
        word_valid = 1'b0;
        rand_rdy   = 1'b0;
        #2 bit_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
